// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_arbiter
// Description : Two-port round-robin arbiter sharing a single-cycle ROM between
//               instruction fetch and data load, with misaligned-load flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic                  ld_gnt,
    output logic                  ld_rvalid,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    output logic                  ld_err,
    output logic                  rom_ce,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    localparam int c_OFF_W = $clog2(DATA_WIDTH / 8);

    logic                  r_last_ld;
    logic                  r_if_rvalid;
    logic                  r_ld_rvalid;
    logic                  r_ld_err;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_ld_rdata;

    logic w_if_gnt;
    logic w_ld_gnt;
    logic w_ld_mis;
    logic w_contest;

    generate
        if (c_OFF_W > 0) begin : g_align_chk
            assign w_ld_mis = |ld_addr[c_OFF_W-1:0];
        end else begin : g_no_align_chk
            assign w_ld_mis = 1'b0;
        end
    endgenerate

    // r_last_ld=1 means load won the last contested cycle, so fetch wins the next
    always_comb begin
        w_contest = if_req & ld_req;
        w_if_gnt  = 1'b0;
        w_ld_gnt  = 1'b0;
        if (!rst) begin
            w_if_gnt = if_req & (~ld_req | r_last_ld);
            w_ld_gnt = ld_req & (~if_req | ~r_last_ld);
        end
    end

    assign if_gnt   = w_if_gnt;
    assign ld_gnt   = w_ld_gnt;
    assign rom_ce   = w_if_gnt | (w_ld_gnt & ~w_ld_mis);
    assign rom_addr = w_if_gnt ? if_addr : (w_ld_gnt ? ld_addr : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_ld   <= 1'b1;
            r_if_rvalid <= 1'b0;
            r_ld_rvalid <= 1'b0;
            r_ld_err    <= 1'b0;
            r_if_rdata  <= '0;
            r_ld_rdata  <= '0;
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_ld_rvalid <= w_ld_gnt;
            r_ld_err    <= w_ld_gnt & w_ld_mis;
            if (w_if_gnt) begin
                r_if_rdata <= rom_data;
            end
            if (w_ld_gnt) begin
                r_ld_rdata <= w_ld_mis ? '0 : rom_data;
            end
            if (w_contest) begin
                r_last_ld <= w_ld_gnt;
            end
        end
    end

    // A response due in a reset cycle is suppressed so a pre-reset grant never surfaces
    assign if_rvalid = r_if_rvalid & ~rst;
    assign ld_rvalid = r_ld_rvalid & ~rst;
    assign ld_err    = r_ld_err & ~rst;
    assign if_rdata  = r_if_rdata;
    assign ld_rdata  = r_ld_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_arbiter
// Description : Scoreboard bench for rom_arbiter with directed scenario tasks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        ld_err;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        ifq[$];
    rsp_t        ldq[$];
    logic        m_last_ld  = 1'b1;
    logic        m_init     = 1'b0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_ld_rdata = '0;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        if (a == 32'h8) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    rom_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_last_ld  = 1'b1;
            m_if_rdata = '0;
            m_ld_rdata = '0;
            m_init     = 1'b1;
        end
    end

    // Reference arbitration and response scoreboard, evaluated mid-cycle
    always @(negedge clk) begin
        logic        eg_if, eg_ld, mis, e_ce, e_v, e_err;
        logic [31:0] e_addr;
        rsp_t        e;
        eg_if  = !rst && if_req && (!ld_req || m_last_ld);
        eg_ld  = !rst && ld_req && (!if_req || !m_last_ld);
        mis    = (ld_addr[1:0] != 2'b00);
        e_ce   = eg_if || (eg_ld && !mis);
        e_addr = eg_if ? if_addr : (eg_ld ? ld_addr : 32'h0);
        n_checks++;
        if ({if_gnt, ld_gnt, rom_ce} !== {eg_if, eg_ld, e_ce} || rom_addr !== e_addr) begin
            n_fail++;
            $display("FAIL sb_grant cyc=%0d: got gnt_if=%b gnt_ld=%b ce=%b addr=%h, want %b %b %b %h",
                     cyc, if_gnt, ld_gnt, rom_ce, rom_addr, eg_if, eg_ld, e_ce, e_addr);
        end
        if (m_init) begin
            e_v = 1'b0;
            if (ifq.size() > 0 && ifq[0].due == cyc) begin
                e = ifq.pop_front();
                m_if_rdata = e.data;
                e_v = !rst;
            end
            n_checks++;
            if (if_rvalid !== e_v || if_rdata !== m_if_rdata) begin
                n_fail++;
                $display("FAIL sb_fetch cyc=%0d: got rvalid=%b rdata=%h, want %b %h",
                         cyc, if_rvalid, if_rdata, e_v, m_if_rdata);
            end
            e_v   = 1'b0;
            e_err = 1'b0;
            if (ldq.size() > 0 && ldq[0].due == cyc) begin
                e = ldq.pop_front();
                m_ld_rdata = e.data;
                e_v   = !rst;
                e_err = !rst && e.err;
            end
            n_checks++;
            if (ld_rvalid !== e_v || ld_err !== e_err || ld_rdata !== m_ld_rdata) begin
                n_fail++;
                $display("FAIL sb_load cyc=%0d: got rvalid=%b err=%b rdata=%h, want %b %b %h",
                         cyc, ld_rvalid, ld_err, ld_rdata, e_v, e_err, m_ld_rdata);
            end
        end
        if (eg_if) ifq.push_back('{due: cyc + 1, data: rom_fn(if_addr), err: 1'b0});
        if (eg_ld) ldq.push_back('{due: cyc + 1, data: (mis ? 32'h0 : rom_fn(ld_addr)), err: mis});
        if (!rst && if_req && ld_req) m_last_ld = eg_ld;
    end

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; ld_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; ld_req = 1'b1; if_addr = 32'h4; ld_addr = 32'h8;
        @(negedge clk); #1;
        n_checks++;
        if ({if_gnt, ld_gnt, rom_ce} !== 3'b000 || rom_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b%b ce=%b addr=%h, want 000 0", if_gnt, ld_gnt, rom_ce, rom_addr);
        end
        n_checks++;
        if ({if_rvalid, ld_rvalid, ld_err} !== 3'b000 || if_rdata !== 32'h0 || ld_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got v=%b%b err=%b rd=%h/%h, want 0 0 0 0/0",
                     if_rvalid, ld_rvalid, ld_err, if_rdata, ld_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b0; ld_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_fetch();
        do_reset();
        if_req = 1'b1; if_addr = 32'h8;
        @(negedge clk); #1;
        n_checks++;
        if (if_gnt !== 1'b1 || rom_ce !== 1'b1 || rom_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL fetch_grant: got gnt=%b ce=%b addr=%h, want 1 1 00000008", if_gnt, rom_ce, rom_addr);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || ld_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_resp: got v=%b rd=%h ldv=%b, want 1 deadbeef 0", if_rvalid, if_rdata, ld_rvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contested();
        logic [3:0] pat;
        pat = 4'b0101;
        do_reset();
        if_req = 1'b1; if_addr = 32'h0; ld_req = 1'b1; ld_addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (if_gnt !== pat[i] || ld_gnt !== !pat[i]) begin
                n_fail++;
                $display("FAIL contest_rr[%0d]: got if=%b ld=%b, want if=%b", i, if_gnt, ld_gnt, pat[i]);
            end
            @(posedge clk); #1;
        end
        if_req = 1'b0; ld_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_uncontested_ld();
        do_reset();
        ld_req = 1'b1; ld_addr = 32'h20;
        repeat (3) @(posedge clk);
        #1 if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk); #1;
        n_checks++;
        if (if_gnt !== 1'b1 || ld_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL uncontested_ptr first: got if=%b ld=%b, want 1 0", if_gnt, ld_gnt);
        end
        @(posedge clk); #1;
        @(negedge clk); #1;
        n_checks++;
        if (if_gnt !== 1'b0 || ld_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL uncontested_ptr second: got if=%b ld=%b, want 0 1", if_gnt, ld_gnt);
        end
        @(posedge clk); #1;
        if_req = 1'b0; ld_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned();
        ld_req = 1'b1; ld_addr = 32'h14;
        @(posedge clk); #1;
        ld_addr = 32'h6;
        @(negedge clk); #1;
        n_checks++;
        if (ld_gnt !== 1'b1 || rom_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_grant: got gnt=%b ce=%b, want 1 0", ld_gnt, rom_ce);
        end
        @(posedge clk); #1;
        ld_req = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (ld_rvalid !== 1'b1 || ld_err !== 1'b1 || ld_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL misalign_resp: got v=%b err=%b rd=%h, want 1 1 0", ld_rvalid, ld_err, ld_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_kill();
        if_req = 1'b1; if_addr = 32'h20;
        @(negedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (if_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_kill N+1: got rvalid=%b, want 0", if_rvalid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_kill N+2: got rvalid=%b rdata=%h, want 0 0", if_rvalid, if_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            if_req  = (i < 16);
            if_addr = 32'(4 * i);
            @(negedge clk); #1;
            if (i > 0) begin
                n_checks++;
                if (if_rvalid !== 1'b1 || if_rdata !== rom_fn(32'(4 * (i - 1)))) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: got v=%b rd=%h, want 1 %h", i - 1, if_rvalid, if_rdata, rom_fn(32'(4 * (i - 1))));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            if_req  = 1'($urandom_range(0, 1));
            ld_req  = 1'($urandom_range(0, 1));
            if_addr = 32'($urandom_range(0, 63) * 4);
            ld_addr = 32'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        if_req = 1'b0; ld_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; ld_req = 1'b0; if_addr = '0; ld_addr = '0;
        test_reset();
        test_single_fetch();
        test_contested();
        test_uncontested_ld();
        test_misaligned();
        test_reset_kill();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of both requesters and the ROM port.
REQ-002 Parameter DATA_WIDTH, default 32, ROM word width; multiple of 8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch request; held with if_addr stable until if_gnt.
REQ-006 if_addr  input  ADDR_WIDTH  fetch byte address.
REQ-007 if_gnt  output  1  combinational; fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  registered; fetch data valid, one cycle wide.
REQ-009 if_rdata  output  DATA_WIDTH  registered fetch data.
REQ-010 ld_req  input  1  data-load request; held with ld_addr stable until ld_gnt.
REQ-011 ld_addr  input  ADDR_WIDTH  load byte address.
REQ-012 ld_gnt  output  1  combinational; load request accepted this cycle.
REQ-013 ld_rvalid  output  1  registered; load data valid, one cycle wide.
REQ-014 ld_rdata  output  DATA_WIDTH  registered load data.
REQ-015 ld_err  output  1  registered; qualifies ld_rvalid, misaligned load.
REQ-016 rom_ce  output  1  ROM chip enable; high only in a grant cycle.
REQ-017 rom_addr  output  ADDR_WIDTH  address of the granted requester; zero when no grant.
REQ-018 rom_data  input  DATA_WIDTH  combinational ROM word for rom_addr.

Function
REQ-019 At most one of if_gnt/ld_gnt SHALL be high per cycle; grant only to an asserted req.
REQ-020 Only one requester asserted: that requester SHALL be granted the same cycle.
REQ-021 Both asserted: grant SHALL go to the requester not granted in the most recent contested cycle (round-robin pointer last_ld, 1 bit).
REQ-022 last_ld SHALL update only in contested cycles: 1 if ld granted, 0 if if granted.
REQ-023 Uncontested grants SHALL NOT change last_ld.
REQ-024 Grant in cycle N: rom_ce=1, rom_addr=granted address; rom_data SHALL be captured at edge N into the granted requester's rdata register.
REQ-025 Latency: rvalid SHALL be high in cycle N+1 only, for the requester granted in N; the other rvalid SHALL be 0.
REQ-026 Back-to-back grants every cycle SHALL be sustained; throughput one word per cycle.
REQ-027 rdata registers SHALL hold their last value when rvalid is 0.
REQ-028 Misalignment: ld_addr[$clog2(DATA_WIDTH/8)-1:0] nonzero SHALL still be granted, rom_ce SHALL be 0 that cycle, ld_rdata SHALL be loaded with zero, ld_err=1 with ld_rvalid in N+1.
REQ-029 ld_err SHALL be 0 whenever ld_rvalid is 0 or the load was aligned.
REQ-030 if_addr low bits SHALL be ignored (fetches treated as aligned; alignment is the fetch unit's job).
REQ-031 A requester deasserting req without grant SHALL leave no state change.
REQ-032 Neither req asserted: rom_ce=0, rom_addr=0, both gnt=0.

Reset
REQ-033 While rst=1: if_gnt=ld_gnt=0, rom_ce=0, rom_addr=0, regardless of req.
REQ-034 At the rst edge: if_rvalid=ld_rvalid=ld_err=0, if_rdata=ld_rdata=0, last_ld=1 (first contested cycle grants fetch).
REQ-035 A grant in the cycle before rst rises SHALL NOT produce rvalid in the rst cycle or after.
REQ-036 First grant possible in the first cycle with rst=0.

Verification
REQ-037 Reset then if_req=1, if_addr=0x8 alone, rom_data=0xDEADBEEF -> if_gnt same cycle, rom_addr=0x8, rom_ce=1; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, ld_rvalid=0.
REQ-038 After reset, both req held 4 cycles (if_addr=0x0, ld_addr=0x10) -> grants if,ld,if,ld; rvalid pattern lags one cycle; rdata matches rom_data of the grant cycle.
REQ-039 ld_req alone 3 cycles, then both asserted -> first contested grant to if (last_ld unchanged by uncontested grants? last_ld=1 from reset), then ld.
REQ-040 ld_req=1, ld_addr=0x6 -> ld_gnt=1, rom_ce=0; next cycle ld_rvalid=1, ld_err=1, ld_rdata=0.
REQ-041 Grant fetch in cycle N, rst=1 in cycle N+1 -> if_rvalid=0 at N+1 and N+2, if_rdata=0.
REQ-042 Continuous if_req with addresses 0x0,0x4,0x8,... 16 cycles -> 16 consecutive if_rvalid pulses, no bubbles, data in address order.
